// File: rtl/chipset_read_router_pkg.sv
// chipset_read_router_pkg: shared state encoding, default idle bus value and
// index-width helper for the chipset read router.
package chipset_read_router_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRIVE,
      HOLD
   } state_t;

   // Value driven on the internal bus when nothing is selected.
   localparam int DEFAULT_IDLE_VALUE = 0;

   // Width of a source index; a single source still needs one bit.
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chipset_read_router_source_priority_encoder.sv
// source_priority_encoder: combinational lowest-index-wins encoder over the
// per-source chip-select decode, with any/multiple-select flags.
module source_priority_encoder
   import chipset_read_router_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int INDEX_WIDTH = index_width(NUM_SOURCES)
) (
   input  logic [NUM_SOURCES-1:0] select,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   any_set,
   output logic                   multiple_set
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      index = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (select[i]) index = INDEX_WIDTH'(i);
      end
      any_set      = |select;
      // Clearing the lowest set bit leaves something only if two were set.
      multiple_set = |(select & (select - NUM_SOURCES'(1)));
   end

endmodule

// File: rtl/chipset_read_router.sv
// chipset_read_router: registered read-data steering for the chipset internal
// data bus. Grants the lowest selected on-chip source at read start, inserts
// its wait states through ready_request, and flags multi-select contention.
// Optional build macro CHIPSET_READ_ROUTER_OPEN_BUS_EN: when defined, the idle
// bus with no inbound external data keeps its previous value instead of
// loading IDLE_VALUE.
module chipset_read_router
   import chipset_read_router_pkg::*;
#(
   parameter int                    NUM_SOURCES = 4,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    WAIT_WIDTH  = 3,
   parameter logic [DATA_WIDTH-1:0] IDLE_VALUE  = DATA_WIDTH'(DEFAULT_IDLE_VALUE),
   localparam int                   INDEX_WIDTH = index_width(NUM_SOURCES)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              read_n,
   input  logic [NUM_SOURCES-1:0]            source_select,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
   input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait,
   input  logic [DATA_WIDTH-1:0]             external_data,
   input  logic                              external_inbound,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              data_out_from_chipset,
   output logic                              ready_request,
   output logic [INDEX_WIDTH-1:0]            selected_index,
   output logic                              contention,
   output logic [7:0]                        contention_count
);

   state_t                  state;
   logic [WAIT_WIDTH-1:0]   wait_cnt;
   logic                    read_n_prev;
   logic [INDEX_WIDTH-1:0]  grant_index;
   logic                    grant_any;
   logic                    grant_multiple;
   logic                    read_start;
   logic [WAIT_WIDTH-1:0]   grant_wait;
   logic [DATA_WIDTH-1:0]   granted_data;
   logic [DATA_WIDTH-1:0]   idle_data;

   source_priority_encoder #(
      .NUM_SOURCES (NUM_SOURCES),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_encoder (
      .select       (source_select),
      .index        (grant_index),
      .any_set      (grant_any),
      .multiple_set (grant_multiple)
   );

   assign read_start   = ~read_n & read_n_prev;
   assign grant_wait   = source_wait[int'(grant_index) * WAIT_WIDTH +: WAIT_WIDTH];
   assign granted_data = source_data[int'(selected_index) * DATA_WIDTH +: DATA_WIDTH];

`ifdef CHIPSET_READ_ROUTER_OPEN_BUS_EN
   assign idle_data = external_inbound ? external_data : data_out;
`else
   assign idle_data = external_inbound ? external_data : IDLE_VALUE;
`endif

   // Read FSM: grant at read start, count wait states, drive then hold data.
   always_ff @(posedge clock) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      if (reset) begin
         state                 <= IDLE;
         wait_cnt              <= '0;
         read_n_prev           <= 1'b1;
         data_out              <= IDLE_VALUE;
         data_out_from_chipset <= 1'b0;
         ready_request         <= 1'b1;
         selected_index        <= '0;
         contention            <= 1'b0;
         contention_count      <= 8'd0;
      end else begin
         read_n_prev <= read_n;
         contention  <= 1'b0;
         case (state)
            IDLE: begin
               ready_request         <= 1'b1;
               data_out_from_chipset <= 1'b0;
               data_out              <= idle_data;
               if (read_start && grant_any) begin
                  selected_index <= grant_index;
                  wait_cnt       <= grant_wait;
                  if (grant_wait != '0) begin
                     state         <= WAIT;
                     ready_request <= 1'b0;
                  end else begin
                     state <= DRIVE;
                  end
                  if (grant_multiple) begin
                     contention <= 1'b1;
                     if (contention_count != 8'hFF) contention_count <= contention_count + 8'd1;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
               if (read_n) begin
                  state         <= IDLE;
                  ready_request <= 1'b1;
               end else if (wait_cnt == WAIT_WIDTH'(1)) begin
                  state         <= DRIVE;
                  ready_request <= 1'b1;
               end else begin
                  ready_request <= 1'b0;
               end
            end
            DRIVE: begin
               ready_request         <= 1'b1;
               data_out_from_chipset <= 1'b1;
               data_out              <= granted_data;
               if (read_n) state <= HOLD;
            end
            HOLD: begin
               ready_request         <= 1'b1;
               data_out_from_chipset <= 1'b1;
               state                 <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chipset_read_router.sv
// tb_chipset_read_router: scoreboard bench. The stimulus process predicts each
// read transaction from the read-cycle rules and queues the prediction; a
// monitor watches the bus outputs over each strobe and compares at its end.
module tb_chipset_read_router;

   localparam int NS = 4;
   localparam int DW = 8;
   localparam int WW = 3;

   typedef struct {
      int         any;
      int         idx;
      int         low;
      int         dofc_n;
      int         first_dofc;
      logic [7:0] data;
      int         cont;
      logic [7:0] count;
      logic [7:0] bus;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset;
   logic             read_n;
   logic [NS-1:0]    source_select;
   logic [NS*DW-1:0] source_data;
   logic [NS*WW-1:0] source_wait;
   logic [DW-1:0]    external_data;
   logic             external_inbound;
   logic [DW-1:0]    data_out;
   logic             data_out_from_chipset;
   logic             ready_request;
   logic [1:0]       selected_index;
   logic             contention;
   logic [7:0]       contention_count;

   int         checks;
   int         errors;
   bit         mon_en;
   int         wait_arr [NS];
   logic [7:0] data_arr [NS];
   int         model_count;
   logic [7:0] model_bus;
   exp_t       exp_q [$];

   chipset_read_router dut (
      .clock                 (clock),
      .reset                 (reset),
      .read_n                (read_n),
      .source_select         (source_select),
      .source_data           (source_data),
      .source_wait           (source_wait),
      .external_data         (external_data),
      .external_inbound      (external_inbound),
      .data_out              (data_out),
      .data_out_from_chipset (data_out_from_chipset),
      .ready_request         (ready_request),
      .selected_index        (selected_index),
      .contention            (contention),
      .contention_count      (contention_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic pack_sources();
      for (int i = 0; i < NS; i++) begin
         source_wait[i*WW +: WW] = WW'(wait_arr[i]);
         source_data[i*DW +: DW] = data_arr[i];
      end
   endtask

   // Transaction-level prediction of one strobe of len clocks.
   function automatic exp_t predict(input logic [NS-1:0] sel, input int len,
                                    input logic inbound, input logic [7:0] ext);
      exp_t e;
      int   n;
      e = '{default: 0};
      e.any = (sel != '0);
      if (e.any) begin
         while (!sel[e.idx]) e.idx++;
         n = wait_arr[e.idx];
         if (len <= n) begin
            e.low = len;                  // strobe released during wait states
         end else begin
            e.low        = n;
            e.dofc_n     = len - n + 1;   // drive cycles plus one hold cycle
            e.first_dofc = n + 2;
            e.data       = data_arr[e.idx];
            model_bus    = e.data;
         end
         if ($countones(sel) > 1) begin
            e.cont = 1;
            if (model_count < 255) model_count++;
         end
      end
      e.count = 8'(model_count);
      if (inbound) model_bus = ext;
`ifndef CHIPSET_READ_ROUTER_OPEN_BUS_EN
      else model_bus = 8'h00;
`endif
      e.bus = model_bus;
      return e;
   endfunction

   task automatic do_read(input logic [NS-1:0] sel, input int len,
                          input logic inbound, input logic [7:0] ext);
      @(posedge clock);
      #1;
      pack_sources();
      exp_q.push_back(predict(sel, len, inbound, ext));
      source_select    = sel;
      external_inbound = inbound;
      external_data    = ext;
      read_n           = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(posedge clock);
         #1;
         if (k == 0) source_select = NS'($urandom);   // must be ignored mid-read
      end
      read_n = 1'b1;
      repeat (5) @(posedge clock);
   endtask

   // Monitor: observe outputs from strobe fall until four idle samples later.
   initial begin : monitor
      bit         active;
      bit         prev_rn;
      bit         unstable;
      int         j, high_n, low, first_low, dofc_n, first_dofc, cont_n;
      logic [7:0] data;
      exp_t       e;
      active  = 1'b0;
      prev_rn = 1'b1;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (!active && prev_rn && !read_n) begin
               active = 1'b1; j = 0; high_n = 0; low = 0; first_low = -1;
               dofc_n = 0; first_dofc = -1; cont_n = 0; data = '0; unstable = 1'b0;
            end
            if (active) begin
               if (!ready_request) begin
                  low++;
                  if (first_low < 0) first_low = j;
               end
               if (data_out_from_chipset) begin
                  dofc_n++;
                  if (first_dofc < 0) begin
                     first_dofc = j;
                     data       = data_out;
                  end else if (data_out !== data) begin
                     unstable = 1'b1;
                  end
               end
               if (contention) cont_n++;
               if (read_n) high_n++;
               j++;
               if (high_n == 4) begin
                  active = 1'b0;
                  check("sb_pending_txn", 32'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("ready_low_cycles", low, e.low);
                     if (e.low > 0) check("ready_fall_cycle", first_low, 1);
                     check("chipset_cycles", dofc_n, e.dofc_n);
                     if (e.dofc_n > 0) begin
                        check("first_data_cycle", first_dofc, e.first_dofc);
                        check("read_data", data, e.data);
                        check("read_data_stable", unstable, 0);
                     end
                     check("contention_pulses", cont_n, e.cont);
                     check("contention_count", contention_count, e.count);
                     if (e.any != 0) check("selected_index", selected_index, e.idx);
                     check("idle_bus_data", data_out, e.bus);
                  end
               end
            end
         end
         prev_rn = read_n;
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      checks = 0; errors = 0; mon_en = 1'b0;
      model_count = 0; model_bus = 8'h00;
      reset = 1'b1; read_n = 1'b1; source_select = '0; source_data = '0;
      source_wait = '0; external_data = '0; external_inbound = 1'b0;
      for (int i = 0; i < NS; i++) begin
         wait_arr[i] = 0;
         data_arr[i] = 8'h00;
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_data_out", data_out, 8'h00);
      check("rst_from_chipset", data_out_from_chipset, 0);
      check("rst_ready", ready_request, 1);
      check("rst_selected_index", selected_index, 0);
      check("rst_contention", contention, 0);
      check("rst_contention_count", contention_count, 0);

      // Reset asserted while a contended read from source 2 is driving.
      wait_arr[2] = 3; data_arr[2] = 8'hA5;
      wait_arr[3] = 1; data_arr[3] = 8'h11;
      pack_sources();
      @(posedge clock);
      #1 source_select = 4'b1100; read_n = 1'b0;
      repeat (6) @(posedge clock);
      @(negedge clock);
      check("pre_rst_from_chipset", data_out_from_chipset, 1);
      check("pre_rst_data", data_out, 8'hA5);
      check("pre_rst_index", selected_index, 2);
      check("pre_rst_count", contention_count, 1);
      @(posedge clock);
      #1 reset = 1'b1; read_n = 1'b1; source_select = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("mid_rst_data_out", data_out, 8'h00);
      check("mid_rst_ready", ready_request, 1);
      check("mid_rst_from_chipset", data_out_from_chipset, 0);
      check("mid_rst_count", contention_count, 0);
      check("mid_rst_index", selected_index, 0);
      repeat (3) @(posedge clock);
      model_count = 0;
      model_bus   = 8'h00;
      mon_en      = 1'b1;

      // Directed reads.
      wait_arr[0] = 0; data_arr[0] = 8'h5A;
      wait_arr[1] = 2; data_arr[1] = 8'h96;
      wait_arr[2] = 3; data_arr[2] = 8'hA5;
      wait_arr[3] = 5; data_arr[3] = 8'hC3;
      do_read(4'b0100, 6, 1'b0, 8'h00);   // three wait states, data 0xA5
      do_read(4'b1000, 2, 1'b0, 8'h00);   // aborted after two wait cycles
      do_read(4'b0000, 3, 1'b1, 8'h3C);   // external inbound read
      do_read(4'b0110, 4, 1'b0, 8'h00);   // contention, index 1
      do_read(4'b0001, 2, 1'b0, 8'h00);   // zero-wait read of 0x5A
      do_read(4'b0000, 2, 1'b0, 8'h00);   // idle bus after it
      for (int r = 0; r < 300; r++) do_read(4'b0110, 3, 1'b0, 8'h00);

      // Randomized reads.
      for (int r = 0; r < 300; r++) begin
         for (int i = 0; i < NS; i++) begin
            wait_arr[i] = $urandom_range(0, 7);
            data_arr[i] = 8'($urandom);
         end
         do_read(NS'($urandom_range(0, 15)), $urandom_range(1, 10),
                 1'($urandom_range(0, 1)), 8'($urandom));
      end

      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clock);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chipset_read_router.md
Name: chipset_read_router

Overview:
- Parametrised, registered read-data steering block for the chipset internal data bus, replacing the fixed two-way chipset/external mux.
- Selects one of NUM_SOURCES on-chip peripheral read ports, or the external bus, during a read strobe.
- Inserts per-source wait states and drives the ready request toward the READY logic.
- Flags decode contention when more than one source is selected.

Parameters:
- NUM_SOURCES, 4, number of on-chip read sources (1..16).
- DATA_WIDTH, 8, data bus width.
- WAIT_WIDTH, 3, width of each per-source wait-state count.
- IDLE_VALUE, 0, value driven when nothing is selected and the external bus is not inbound.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- read_n  in  1  combined active-low read strobe (io_read_n AND memory_read_n).
- source_select  in  NUM_SOURCES  per-source chip-select decode, active-high.
- source_data  in  NUM_SOURCES*DATA_WIDTH  per-source read data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- source_wait  in  NUM_SOURCES*WAIT_WIDTH  per-source wait-state count, quasi-static.
- external_data  in  DATA_WIDTH  data from the external bus.
- external_inbound  in  1  1 = external bus is driving inward (data direction = 1).
- data_out  out  DATA_WIDTH  registered internal-bus read data.
- data_out_from_chipset  out  1  1 = data_out comes from an on-chip source.
- ready_request  out  1  0 = insert a wait state.
- selected_index  out  $clog2(NUM_SOURCES) (min 1)  index of the granted source.
- contention  out  1  one-cycle pulse on a multi-select read start.
- contention_count  out  8  saturating count of contention events.

Behaviour:
- All registers update on the rising edge of clock.
- Reset dominates every other event in the same cycle. Reset values:
  - state IDLE
  - data_out = IDLE_VALUE
  - data_out_from_chipset = 0
  - ready_request = 1
  - selected_index = 0
  - contention = 0
  - contention_count = 0
  - read_n_prev = 1
- Read start is the cycle where read_n == 0 and read_n_prev == 1.
- Grant rule: lowest-index set bit of source_select wins. The grant is taken only at read start; select changes mid-read are ignored.
- States:
  - IDLE:
    - ready_request = 1; data_out_from_chipset = 0.
    - data_out <= external_data if external_inbound, else IDLE_VALUE.
    - On read start with any select bit set: latch index; load wait_cnt <= source_wait[index]; go to WAIT if the count is nonzero, else DRIVE.
    - If more than one select bit is set at read start: contention = 1 for that cycle; contention_count increments, saturating at 255.
    - On read start with no select bit set: remain in IDLE (external/idle path).
  - WAIT:
    - ready_request = 0; wait_cnt decrements each cycle.
    - When wait_cnt == 1, go to DRIVE.
    - If read_n returns to 1 in WAIT (aborted cycle), go to IDLE with ready_request = 1 and no data drive.
  - DRIVE:
    - ready_request = 1; data_out_from_chipset = 1.
    - data_out <= source_data[index], re-sampled every cycle.
    - When read_n rises, go to HOLD.
  - HOLD:
    - One cycle keeping the last data_out with data_out_from_chipset = 1 (covers data hold past strobe end).
    - Then go to IDLE.
    - A read start in HOLD is deferred: it is evaluated in IDLE on the next cycle only if read_n_prev == 1.
- Latency and wait insertion:
  - data_out is valid one clock after entry to DRIVE.
  - ready_request falls the cycle after read start.
  - With N wait states, ready_request is low for exactly N cycles.
- data_out_from_chipset and data_out are both registered; there is no combinational input-to-output path.

Optional Feature:
- Macro: CHIPSET_READ_ROUTER_OPEN_BUS_EN.
- With the macro defined: in IDLE with external_inbound == 0, data_out holds its previous value (floating-bus emulation) instead of loading IDLE_VALUE.
- Without the macro: IDLE_VALUE is loaded, as described above.
- Reset value of data_out is IDLE_VALUE in both builds.

Decomposition:
- Shared package chipset_read_router_pkg holds:
  - state enum {IDLE, WAIT, DRIVE, HOLD}
  - default IDLE_VALUE constant
  - index-width helper function.
- One sub-module: source_priority_encoder.
  - Combinational; NUM_SOURCES-wide one-hot/multi-hot input.
  - Outputs: index, any_set, multiple_set.

Test Plan:
- Reset asserted mid-DRIVE -> next cycle: state IDLE, data_out = 0x00, ready_request = 1, contention_count = 0.
- Source 2 selected, source_wait[2] = 3, source_data[2] = 0xA5 -> ready_request low exactly 3 cycles; data_out = 0xA5 with data_out_from_chipset = 1 until one cycle after read_n rises.
- Selects 0b0110 at read start -> selected_index = 1, contention pulses 1 cycle, contention_count 0 -> 1; 300 such reads -> count = 255.
- Read with no select, external_inbound = 1, external_data = 0x3C -> data_out = 0x3C, data_out_from_chipset = 0, ready_request stays 1.
- source_wait = 5 and read_n released after 2 wait cycles -> return to IDLE, ready_request = 1, data_out_from_chipset never asserted.
- With CHIPSET_READ_ROUTER_OPEN_BUS_EN: read 0x5A from source 0, then idle with no inbound -> data_out stays 0x5A; without the macro -> 0x00.
